mem_stage_hs: RTL and testbench
===============================

Name: mem_stage_hs

Overview:
Parametrised successor to the single-cycle memory stage. It sits between EX and WB in the 5-stage RV32I pipeline and talks to a variable-latency data memory over a req/gnt/rvalid handshake. Internally it does load byte/half alignment and sign/zero extension, store byte-enable and lane generation, and misaligned-access exception detection. It keeps the valid/allow_in pipeline handshake and the ID bypass, and adds flush support with drain of outstanding memory responses.

Parameters:
ADDR_W, 32, width of dmem_addr and ex_addr
REG_AW, 5, register-index width
CHECK_ALIGN, 1, 1 = misaligned access raises an exception; 0 = address low bits are ignored for lane selection of half/word accesses (forced alignment), no exception
EXC_LD_MISALIGN, 4, cause code for a misaligned load
EXC_ST_MISALIGN, 6, cause code for a misaligned store

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
ex_valid  in  1  EX presents an instruction
mem_allow_in  out  1  stage can accept this cycle
ex_mem_re / ex_mem_we  in  1/1  load / store
ex_size  in  2  0 byte, 1 half, 2 word
ex_unsigned  in  1  zero-extend load
ex_addr  in  ADDR_W  effective address
ex_wdata  in  32  store data (low bits significant)
ex_rf_we  in  1  writes rd
ex_wb_reg  in  REG_AW  rd
ex_wb_data  in  32  non-load result (ALU/PC4/EXT/CSR already selected)
flush  in  1  kill stage contents
dmem_req  out  1  request valid
dmem_we  out  1  write
dmem_addr  out  ADDR_W  word-aligned address (low 2 bits zero)
dmem_be  out  4  byte enables
dmem_wdata  out  32  lane-replicated store data
dmem_gnt  in  1  request accepted
dmem_rvalid  in  1  response (one per granted request, loads and stores)
dmem_rdata  in  32  load data
wb_allow_in  in  1  WB can accept
wb_valid  out  1  result valid to WB
wb_rf_we / wb_reg / wb_data  out  1/REG_AW/32  writeback fields; wb_rf_we forced 0 on exception
exc_valid / exc_cause / exc_tval  out  1/5/ADDR_W  exception, qualified by wb_valid
fwd_valid / fwd_ready  out  1/1  stage holds an instruction / its wb_data is final
fwd_rf_we / fwd_reg / fwd_data  out  1/REG_AW/32  bypass to ID

Behaviour:
- States: EMPTY, REQ, WAIT, DONE, DRAIN. Reset: EMPTY; wb_valid, dmem_req, exc_valid, fwd_valid, fwd_ready = 0; data outputs 0.
- Outputs: mem_allow_in = (EMPTY) | (DONE & wb_allow_in). wb_valid = DONE. fwd_ready = DONE.
- Accept when ex_valid & mem_allow_in & !flush. Latch all ex_* fields.
  - Non-memory op → DONE.
  - Misaligned with CHECK_ALIGN=1 (half with addr[0]=1; word with addr[1:0]≠0) → DONE with exc_valid. exc_tval = addr, cause per load/store. No request is issued.
  - Otherwise → REQ.
- Without an accept, DONE & wb_allow_in → EMPTY.
- REQ: dmem_req=1 with stable addr/we/be/wdata until dmem_gnt. On gnt → WAIT.
- WAIT: dmem_rvalid captures the extended load data into wb_data (stores keep ex_wb_data) → DONE. rvalid arrives no earlier than the cycle after gnt; rvalid outside WAIT/DRAIN is ignored.
- Load extend: byte lane = addr[1:0]; half lane = addr[1]; sign-extend unless ex_unsigned.
- Store be: byte 0001<<addr[1:0]; half 0011<<{addr[1],0}; word 1111. wdata = byte×4 / half×2 / word.
- Minimum latency:
  - non-mem op accepted at edge N → wb_valid in cycle N+1.
  - load with gnt in N+1 and rvalid in N+2 → wb_valid in N+3.
- Flush:
  - In EMPTY/DONE: → EMPTY.
  - In REQ without gnt that cycle: → EMPTY; the request is withdrawn.
  - In REQ with gnt that cycle, or in WAIT without rvalid: → DRAIN.
  - In WAIT with rvalid: → EMPTY.
  - DRAIN: mem_allow_in=0, fwd_valid=0; on rvalid → EMPTY. A flush inside DRAIN has no further effect.
  - flush & ex_valid in the same cycle: nothing is latched.
- Bypass: fwd_valid = state ∈ {REQ, WAIT, DONE}. ID must stall on a match with fwd_ready=0.
- Reset mid-transaction returns to EMPTY. The memory side is reset in the same cycle.

Test Plan:
- Back-to-back ALU ops, wb_allow_in=1 → one wb_valid per cycle, latency 1, wb_data = ex_wb_data.
- lb addr 0x103, rdata 0x80FF_0000 → wb_data 0xFFFF_FF80. lbu → 0x0000_0080. lh addr 0x102 → 0xFFFF_80FF.
- sb addr 0x101 data 0xAB → be 0010, wdata 0xABABABAB, dmem_addr 0x100. sh addr 0x102 → be 1100.
- lw addr 0x102, CHECK_ALIGN=1 → no dmem_req, exc_valid=1, cause 4, tval 0x102, wb_rf_we=0.
- Load with gnt delayed 3 cycles, rvalid 2 cycles later, wb_allow_in low 2 cycles → req held stable, mem_allow_in=0 throughout, single wb_valid held until accepted.
- flush in WAIT → DRAIN, mem_allow_in=0 until rvalid. Next accepted load gets its own rvalid data, not the stale one.

Source files
------------

// File: rtl/mem_stage_hs_if.sv
// rtl/mem_stage_hs_if.sv - data-memory req/gnt/rvalid bus between the memory stage and dmem
interface mem_stage_hs_if #(
    parameter int ADDR_W = 32
);
    logic              dmem_req;
    logic              dmem_we;
    logic [ADDR_W-1:0] dmem_addr;
    logic [3:0]        dmem_be;
    logic [31:0]       dmem_wdata;
    logic              dmem_gnt;
    logic              dmem_rvalid;
    logic [31:0]       dmem_rdata;

    modport master (
        output dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
        input  dmem_gnt, dmem_rvalid, dmem_rdata
    );

    modport slave (
        input  dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
        output dmem_gnt, dmem_rvalid, dmem_rdata
    );
endinterface

// File: rtl/mem_stage_hs.sv
// rtl/mem_stage_hs.sv - pipeline memory stage with variable-latency dmem handshake, flush and drain
module mem_stage_hs #(
    parameter int ADDR_W          = 32,
    parameter int REG_AW          = 5,
    parameter int CHECK_ALIGN     = 1,
    parameter int EXC_LD_MISALIGN = 4,
    parameter int EXC_ST_MISALIGN = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ex_valid,
    output logic              mem_allow_in,
    input  logic              ex_mem_re,
    input  logic              ex_mem_we,
    input  logic [1:0]        ex_size,
    input  logic              ex_unsigned,
    input  logic [ADDR_W-1:0] ex_addr,
    input  logic [31:0]       ex_wdata,
    input  logic              ex_rf_we,
    input  logic [REG_AW-1:0] ex_wb_reg,
    input  logic [31:0]       ex_wb_data,
    input  logic              flush,
    mem_stage_hs_if.master    dmem,
    input  logic              wb_allow_in,
    output logic              wb_valid,
    output logic              wb_rf_we,
    output logic [REG_AW-1:0] wb_reg,
    output logic [31:0]       wb_data,
    output logic              exc_valid,
    output logic [4:0]        exc_cause,
    output logic [ADDR_W-1:0] exc_tval,
    output logic              fwd_valid,
    output logic              fwd_ready,
    output logic              fwd_rf_we,
    output logic [REG_AW-1:0] fwd_reg,
    output logic [31:0]       fwd_data
);
    typedef enum logic [2:0] {EMPTY, REQ, WAIT, DONE, DRAIN} state_t;

    state_t            state_q, state_d;
    logic              re_q, re_d, we_q, we_d, uns_q, uns_d;
    logic              rf_we_q, rf_we_d, exc_q, exc_d;
    logic [1:0]        size_q, size_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [3:0]        be_q, be_d;
    logic [31:0]       wdata_q, wdata_d, data_q, data_d;
    logic [REG_AW-1:0] reg_q, reg_d;
    logic [4:0]        cause_q, cause_d;

    logic        accept, is_mem, misalign;
    logic [3:0]  st_be;
    logic [31:0] st_wdata;

    function automatic logic [31:0] load_ext(input logic [31:0] rd, input logic [1:0] a,
                                             input logic [1:0] sz, input logic uns);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        case (a)
            2'd0:    b = rd[7:0];
            2'd1:    b = rd[15:8];
            2'd2:    b = rd[23:16];
            default: b = rd[31:24];
        endcase
        h = a[1] ? rd[31:16] : rd[15:0];
        case (sz)
            2'd0:    r = {{24{~uns & b[7]}}, b};
            2'd1:    r = {{16{~uns & h[15]}}, h};
            default: r = rd;
        endcase
        return r;
    endfunction

    assign mem_allow_in = (state_q == EMPTY) | ((state_q == DONE) & wb_allow_in);
    assign accept       = ex_valid & mem_allow_in & ~flush;
    assign is_mem       = ex_mem_re | ex_mem_we;
    // With alignment checking off, lane selection simply uses addr[1] for halves and nothing for words.
    assign misalign     = (CHECK_ALIGN != 0) & is_mem &
                          (((ex_size == 2'd1) & ex_addr[0]) | (ex_size[1] & (ex_addr[1:0] != 2'b00)));

    always_comb begin
        st_be    = 4'b1111;
        st_wdata = ex_wdata;
        case (ex_size)
            2'd0: begin
                st_be    = 4'b0001 << ex_addr[1:0];
                st_wdata = {4{ex_wdata[7:0]}};
            end
            2'd1: begin
                st_be    = ex_addr[1] ? 4'b1100 : 4'b0011;
                st_wdata = {2{ex_wdata[15:0]}};
            end
            default: ;
        endcase
    end

    always_comb begin
        state_d = state_q;
        re_d    = re_q;
        we_d    = we_q;
        uns_d   = uns_q;
        rf_we_d = rf_we_q;
        exc_d   = exc_q;
        size_d  = size_q;
        addr_d  = addr_q;
        be_d    = be_q;
        wdata_d = wdata_q;
        data_d  = data_q;
        reg_d   = reg_q;
        cause_d = cause_q;
        if (accept) begin
            re_d    = ex_mem_re;
            we_d    = ex_mem_we;
            uns_d   = ex_unsigned;
            rf_we_d = ex_rf_we;
            exc_d   = misalign;
            size_d  = ex_size;
            addr_d  = ex_addr;
            be_d    = st_be;
            wdata_d = st_wdata;
            data_d  = ex_wb_data;
            reg_d   = ex_wb_reg;
            cause_d = ex_mem_we ? 5'(EXC_ST_MISALIGN) : 5'(EXC_LD_MISALIGN);
            state_d = (is_mem & ~misalign) ? REQ : DONE;
        end else begin
            case (state_q)
                REQ: begin
                    if (flush)              state_d = dmem.dmem_gnt ? DRAIN : EMPTY;
                    else if (dmem.dmem_gnt) state_d = WAIT;
                end
                WAIT: begin
                    if (dmem.dmem_rvalid) begin
                        state_d = flush ? EMPTY : DONE;
                        if (re_q) data_d = load_ext(dmem.dmem_rdata, addr_q[1:0], size_q, uns_q);
                    end else if (flush) begin
                        state_d = DRAIN;
                    end
                end
                DONE:    if (flush | wb_allow_in) state_d = EMPTY;
                DRAIN:   if (dmem.dmem_rvalid) state_d = EMPTY;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= EMPTY;
            re_q    <= 1'b0;
            we_q    <= 1'b0;
            uns_q   <= 1'b0;
            rf_we_q <= 1'b0;
            exc_q   <= 1'b0;
            size_q  <= '0;
            addr_q  <= '0;
            be_q    <= '0;
            wdata_q <= '0;
            data_q  <= '0;
            reg_q   <= '0;
            cause_q <= '0;
        end else begin
            state_q <= state_d;
            re_q    <= re_d;
            we_q    <= we_d;
            uns_q   <= uns_d;
            rf_we_q <= rf_we_d;
            exc_q   <= exc_d;
            size_q  <= size_d;
            addr_q  <= addr_d;
            be_q    <= be_d;
            wdata_q <= wdata_d;
            data_q  <= data_d;
            reg_q   <= reg_d;
            cause_q <= cause_d;
        end
    end

    // The request is dropped as soon as reset is seen so the memory never grants during reset.
    assign dmem.dmem_req   = (state_q == REQ) & ~rst;
    assign dmem.dmem_we    = we_q;
    assign dmem.dmem_addr  = {addr_q[ADDR_W-1:2], 2'b00};
    assign dmem.dmem_be    = be_q;
    assign dmem.dmem_wdata = wdata_q;

    assign wb_valid  = (state_q == DONE);
    assign wb_rf_we  = rf_we_q & ~exc_q;
    assign wb_reg    = reg_q;
    assign wb_data   = data_q;
    assign exc_valid = exc_q & (state_q == DONE);
    assign exc_cause = cause_q;
    assign exc_tval  = addr_q;

    assign fwd_valid = (state_q == REQ) | (state_q == WAIT) | (state_q == DONE);
    assign fwd_ready = (state_q == DONE);
    assign fwd_rf_we = wb_rf_we;
    assign fwd_reg   = reg_q;
    assign fwd_data  = data_q;
endmodule

// File: tb/tb_mem_stage_hs.sv
// tb/tb_mem_stage_hs.sv - directed and randomized self-checking bench for mem_stage_hs
module tb_mem_stage_hs;
    logic        clk = 1'b0;
    logic        rst;
    logic        ex_valid, ex_mem_re, ex_mem_we, ex_unsigned, ex_rf_we, flush, wb_allow_in;
    logic [1:0]  ex_size;
    logic [31:0] ex_addr, ex_wdata, ex_wb_data;
    logic [4:0]  ex_wb_reg;
    logic        mem_allow_in, wb_valid, wb_rf_we, exc_valid, fwd_valid, fwd_ready, fwd_rf_we;
    logic [4:0]  wb_reg, exc_cause, fwd_reg;
    logic [31:0] wb_data, exc_tval, fwd_data;

    int compared   = 0;
    int mismatched = 0;
    logic [31:0] last_wb;

    always #5 clk = ~clk;

    mem_stage_hs_if #(.ADDR_W(32)) dmem ();

    mem_stage_hs dut (
        .clk(clk), .rst(rst), .ex_valid(ex_valid), .mem_allow_in(mem_allow_in),
        .ex_mem_re(ex_mem_re), .ex_mem_we(ex_mem_we), .ex_size(ex_size),
        .ex_unsigned(ex_unsigned), .ex_addr(ex_addr), .ex_wdata(ex_wdata),
        .ex_rf_we(ex_rf_we), .ex_wb_reg(ex_wb_reg), .ex_wb_data(ex_wb_data),
        .flush(flush), .dmem(dmem), .wb_allow_in(wb_allow_in), .wb_valid(wb_valid),
        .wb_rf_we(wb_rf_we), .wb_reg(wb_reg), .wb_data(wb_data), .exc_valid(exc_valid),
        .exc_cause(exc_cause), .exc_tval(exc_tval), .fwd_valid(fwd_valid),
        .fwd_ready(fwd_ready), .fwd_rf_we(fwd_rf_we), .fwd_reg(fwd_reg), .fwd_data(fwd_data)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] m_load(input logic [31:0] rd, input logic [31:0] a,
                                           input int sz, input bit uns);
        logic [31:0] v;
        if (sz == 0) begin
            v = (rd >> (8 * (a % 4))) & 32'hFF;
            if (!uns && v >= 32'd128) v = v + 32'hFFFF_FF00;
        end else if (sz == 1) begin
            v = (rd >> (16 * ((a / 2) % 2))) & 32'hFFFF;
            if (!uns && v >= 32'd32768) v = v + 32'hFFFF_0000;
        end else begin
            v = rd;
        end
        return v;
    endfunction

    function automatic logic [3:0] m_be(input logic [31:0] a, input int sz);
        if (sz == 0) return 4'(1 << (a % 4));
        if (sz == 1) return 4'(3 << (2 * ((a / 2) % 2)));
        return 4'hF;
    endfunction

    function automatic logic [31:0] m_wd(input logic [31:0] d, input int sz);
        if (sz == 0) return (d & 32'hFF) * 32'h0101_0101;
        if (sz == 1) return (d & 32'hFFFF) * 32'h0001_0001;
        return d;
    endfunction

    task automatic present(input bit re, input bit we, input int sz, input bit uns,
                           input logic [31:0] a, input logic [31:0] wd, input bit rfwe,
                           input logic [4:0] rg, input logic [31:0] wbd);
        ex_valid = 1'b1; ex_mem_re = re; ex_mem_we = we; ex_size = 2'(sz); ex_unsigned = uns;
        ex_addr = a; ex_wdata = wd; ex_rf_we = rfwe; ex_wb_reg = rg; ex_wb_data = wbd;
    endtask

    // Called at a negedge with the stage empty; returns at a negedge with the stage empty again.
    task automatic run_op(input string tag, input bit re, input bit we, input int sz, input bit uns,
                          input logic [31:0] a, input logic [31:0] wd, input bit rfwe,
                          input logic [4:0] rg, input logic [31:0] wbd, input int gd,
                          input int rdly, input logic [31:0] rdata, input int stall);
        bit mis;
        logic [31:0] exp_data;
        mis = (re || we) && ((a % (32'd1 << sz)) != 0);
        exp_data = wbd;
        check({tag, "_allow_empty"}, mem_allow_in, 1);
        present(re, we, sz, uns, a, wd, rfwe, rg, wbd);
        @(negedge clk);
        ex_valid = 1'b0;
        if ((re || we) && !mis) begin
            for (int i = 0; i <= gd; i++) begin
                check({tag, "_req"}, dmem.dmem_req, 1);
                check({tag, "_req_we"}, dmem.dmem_we, we);
                check({tag, "_req_addr"}, dmem.dmem_addr, a & ~32'd3);
                check({tag, "_req_be"}, dmem.dmem_be, m_be(a, sz));
                if (we) check({tag, "_req_wdata"}, dmem.dmem_wdata, m_wd(wd, sz));
                check({tag, "_allow_req"}, mem_allow_in, 0);
                if (i == gd) dmem.dmem_gnt = 1'b1;
                @(negedge clk);
                dmem.dmem_gnt = 1'b0;
            end
            for (int j = 0; j <= rdly; j++) begin
                check({tag, "_wait_noreq"}, dmem.dmem_req, 0);
                check({tag, "_wait_fwd"}, {fwd_valid, fwd_ready, wb_valid}, 3'b100);
                if (j == rdly) begin
                    dmem.dmem_rvalid = 1'b1;
                    dmem.dmem_rdata  = rdata;
                end
                @(negedge clk);
                dmem.dmem_rvalid = 1'b0;
                dmem.dmem_rdata  = $urandom;
            end
            if (re) exp_data = m_load(rdata, a, sz, uns);
        end
        for (int k = 0; k <= stall; k++) begin
            if (k == 0) last_wb = wb_data;
            check({tag, "_wb_valid"}, wb_valid, 1);
            check({tag, "_wb_data"}, wb_data, exp_data);
            check({tag, "_wb_rf_we"}, wb_rf_we, rfwe && !mis);
            check({tag, "_wb_reg"}, wb_reg, rg);
            check({tag, "_exc"}, exc_valid, mis);
            if (mis) begin
                check({tag, "_cause"}, exc_cause, we ? 5'd6 : 5'd4);
                check({tag, "_tval"}, exc_tval, a);
            end
            check({tag, "_done_noreq"}, dmem.dmem_req, 0);
            check({tag, "_fwd_done"}, {fwd_valid, fwd_ready}, 2'b11);
            wb_allow_in = (k == stall);
            @(negedge clk);
        end
        wb_allow_in = 1'b1;
        check({tag, "_retired"}, wb_valid, 0);
    endtask

    initial begin
        logic [31:0] q_data[$];
        logic [4:0]  q_reg[$];
        logic [31:0] d;
        logic [4:0]  r;
        int kind, sz;

        rst = 1'b1; ex_valid = 1'b0; flush = 1'b0; wb_allow_in = 1'b1;
        present(0, 0, 0, 0, 0, 0, 0, 0, 0); ex_valid = 1'b0;
        dmem.dmem_gnt = 1'b0; dmem.dmem_rvalid = 1'b0; dmem.dmem_rdata = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check("rst_state", {mem_allow_in, wb_valid, dmem.dmem_req, exc_valid, fwd_valid, fwd_ready}, 6'b100000);
        check("rst_data", {wb_data, dmem.dmem_addr}, 64'd0);

        // Back-to-back ALU ops: one result per cycle, latency one.
        for (int i = 0; i < 8; i++) begin
            if (i > 0) begin
                check("b2b_valid", wb_valid, 1);
                check("b2b_data", wb_data, q_data.pop_front());
                check("b2b_reg", wb_reg, q_reg.pop_front());
            end
            d = $urandom; r = 5'($urandom);
            present(0, 0, 2, 0, 32'h0, 32'h0, 1, r, d);
            q_data.push_back(d); q_reg.push_back(r);
            @(negedge clk);
        end
        ex_valid = 1'b0;
        check("b2b_last", wb_data, q_data.pop_front());
        void'(q_reg.pop_front());
        @(negedge clk);
        check("b2b_drained", wb_valid, 0);

        run_op("lb",  1, 0, 0, 0, 32'h103, 0, 1, 5'd3, 32'h1111, 0, 0, 32'h80FF_0000, 0);
        check("lb_const", last_wb, 32'hFFFF_FF80);
        run_op("lbu", 1, 0, 0, 1, 32'h103, 0, 1, 5'd4, 32'h2222, 0, 0, 32'h80FF_0000, 0);
        check("lbu_const", last_wb, 32'h0000_0080);
        run_op("lh",  1, 0, 1, 0, 32'h102, 0, 1, 5'd5, 32'h3333, 0, 0, 32'h80FF_0000, 0);
        check("lh_const", last_wb, 32'hFFFF_80FF);
        run_op("sb",  0, 1, 0, 0, 32'h101, 32'h1234_56AB, 0, 5'd0, 32'h4444, 0, 1, 32'h0, 0);
        run_op("sh",  0, 1, 1, 0, 32'h102, 32'h0000_BEEF, 0, 5'd0, 32'h5555, 1, 0, 32'h0, 0);
        run_op("lw_mis", 1, 0, 2, 0, 32'h102, 0, 1, 5'd6, 32'h6666, 0, 0, 32'h0, 0);
        run_op("sw_mis", 0, 1, 2, 0, 32'h201, 0, 1, 5'd7, 32'h7777, 0, 0, 32'h0, 1);
        run_op("lw_slow", 1, 0, 2, 0, 32'h108, 0, 1, 5'd8, 32'h8888, 3, 2, 32'hCAFE_F00D, 2);

        // Flush in WAIT: drain the stale response, then a fresh load gets its own data.
        present(1, 0, 2, 0, 32'h300, 0, 1, 5'd9, 0);
        @(negedge clk);
        ex_valid = 1'b0; dmem.dmem_gnt = 1'b1;
        @(negedge clk);
        dmem.dmem_gnt = 1'b0; flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        present(0, 0, 2, 0, 0, 0, 1, 5'd10, 32'h5A5A);
        check("drain_state", {mem_allow_in, fwd_valid, wb_valid}, 3'b000);
        @(negedge clk);
        check("drain_hold", {mem_allow_in, fwd_valid, wb_valid}, 3'b000);
        ex_valid = 1'b0; dmem.dmem_rvalid = 1'b1; dmem.dmem_rdata = 32'hDEAD_BEEF;
        @(negedge clk);
        dmem.dmem_rvalid = 1'b0;
        check("drain_done", {mem_allow_in, wb_valid}, 2'b10);
        run_op("after_drain", 1, 0, 2, 0, 32'h304, 0, 1, 5'd11, 0, 0, 0, 32'h0123_4567, 0);

        // Flush in REQ without grant withdraws the request.
        present(1, 0, 2, 0, 32'h400, 0, 1, 5'd12, 0);
        @(negedge clk);
        ex_valid = 1'b0; flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("flush_req", {dmem.dmem_req, mem_allow_in, fwd_valid}, 3'b010);

        // Flush in REQ with grant goes to DRAIN until the response.
        present(0, 1, 2, 0, 32'h404, 32'h1, 0, 5'd0, 0);
        @(negedge clk);
        ex_valid = 1'b0; flush = 1'b1; dmem.dmem_gnt = 1'b1;
        @(negedge clk);
        flush = 1'b0; dmem.dmem_gnt = 1'b0;
        check("flush_gnt_drain", {dmem.dmem_req, mem_allow_in, fwd_valid}, 3'b000);
        dmem.dmem_rvalid = 1'b1;
        @(negedge clk);
        dmem.dmem_rvalid = 1'b0;
        check("flush_gnt_empty", mem_allow_in, 1);

        // Flush with ex_valid: nothing latched. Then flush in DONE.
        present(0, 0, 0, 0, 0, 0, 1, 5'd13, 32'h99);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0; ex_valid = 1'b0;
        check("flush_ex_valid", {wb_valid, fwd_valid}, 2'b00);
        present(0, 0, 0, 0, 0, 0, 1, 5'd14, 32'h98);
        @(negedge clk);
        ex_valid = 1'b0; wb_allow_in = 1'b0; flush = 1'b1;
        check("done_before_flush", wb_valid, 1);
        @(negedge clk);
        flush = 1'b0; wb_allow_in = 1'b1;
        check("flush_done", {wb_valid, mem_allow_in}, 2'b01);

        // Reset while a request is pending.
        present(1, 0, 2, 0, 32'h500, 0, 1, 5'd15, 0);
        @(negedge clk);
        ex_valid = 1'b0; rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rst_mid", {dmem.dmem_req, mem_allow_in, fwd_valid}, 3'b010);

        for (int n = 0; n < 40; n++) begin
            kind = $urandom_range(0, 2);
            sz   = $urandom_range(0, 2);
            run_op("rand", kind == 1, kind == 2, sz, 1'($urandom),
                   32'h1000 + 32'($urandom_range(0, 255)), $urandom, 1'($urandom),
                   5'($urandom), $urandom, $urandom_range(0, 2), $urandom_range(0, 2),
                   $urandom, $urandom_range(0, 1));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
